vedic_multiplier_seq: RTL and testbench



---
 rtl/vedic_multiplier_seq_pkg.sv | 18 +
 rtl/vedic_multiplier_seq_if.sv | 33 +++
 rtl/vedic_multiplier_seq_column_adder.sv | 24 ++
 rtl/vedic_multiplier_seq.sv | 121 ++++++++++++
 tb/tb_vedic_multiplier_seq.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/vedic_multiplier_seq_pkg.sv
// Shared types and sizing helpers for the sequential Vedic multiplier.
// Optional signed operation is enabled by defining VEDIC_SIGNED_EN.
package vedic_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // A column sum is at most carry + WIDTH, which stays below 2*WIDTH.
    function automatic int carry_width(input int width);
        return $clog2(2 * width) + 1;
    endfunction

endpackage

// File: rtl/vedic_multiplier_seq_if.sv
// Operand/result handshake bundle for vedic_multiplier_seq.
// signed_op exists only when VEDIC_SIGNED_EN is defined.
interface vedic_multiplier_seq_if #(
    parameter int WIDTH = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
`ifdef VEDIC_SIGNED_EN
    logic               signed_op;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] Produto;
    logic               busy;

    modport master (
        output in_valid, A, B, out_ready,
`ifdef VEDIC_SIGNED_EN
        output signed_op,
`endif
        input  in_ready, out_valid, Produto, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
`ifdef VEDIC_SIGNED_EN
        input  signed_op,
`endif
        output in_ready, out_valid, Produto, busy
    );
endinterface

// File: rtl/vedic_multiplier_seq_column_adder.sv
// Crosswise AND-and-popcount for one product column k, plus incoming carry.
module vedic_column_adder #(
    parameter int WIDTH = 4,
    parameter int CW    = 4,
    parameter int KW    = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    input  logic [CW-1:0]    carry,
    output logic [CW-1:0]    colsum
);
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        colsum = carry;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (i + j == int'(k)) begin
                    colsum = colsum + CW'(a[i] & b[j]);
                end
            end
        end
    end
endmodule

// File: rtl/vedic_multiplier_seq.sv
// Sequential Urdhva-Tiryagbhyam multiplier: one product column per clock.
// Define VEDIC_SIGNED_EN to add two's-complement operation via signed_op.
module vedic_multiplier_seq
    import vedic_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    vedic_multiplier_seq_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = carry_width(WIDTH);
    localparam int KW = $clog2(PW);
    localparam logic [KW-1:0] K_LAST = KW'(PW - 2);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("vedic_multiplier_seq: WIDTH %0d outside 2..%0d", WIDTH, MAX_WIDTH);
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, a_in, b_in;
    logic              neg_q, neg_in;
    logic [KW-1:0]     k_q;
    logic [CW-1:0]     carry_q, colsum;
    logic [PW-1:0]     prod_q, prod_col, prod_fin;
    logic              accept, last_col;
    logic              in_ready, out_valid, busy;

`ifdef VEDIC_SIGNED_EN
    // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
    always_comb begin
        a_in   = bus.A;
        b_in   = bus.B;
        neg_in = 1'b0;
        if (bus.signed_op) begin
            a_in   = bus.A[WIDTH-1] ? -bus.A : bus.A;
            b_in   = bus.B[WIDTH-1] ? -bus.B : bus.B;
            neg_in = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
        end
    end
`else
    assign a_in   = bus.A;
    assign b_in   = bus.B;
    assign neg_in = 1'b0;
`endif

    vedic_column_adder #(.WIDTH(WIDTH), .CW(CW), .KW(KW)) u_col (
        .a      (a_q),
        .b      (b_q),
        .k      (k_q),
        .carry  (carry_q),
        .colsum (colsum)
    );

    assign accept   = bus.in_valid && in_ready;
    assign last_col = (k_q == K_LAST);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_col) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The top column also deposits the final carry; sign is applied on that same load.
    always_comb begin
        prod_col         = prod_q;
        prod_col[k_q]    = colsum[0];
        if (last_col) prod_col[PW-1] = colsum[1];
        prod_fin = (last_col && neg_q) ? -prod_col : prod_col;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            k_q     <= '0;
            carry_q <= '0;
            prod_q  <= '0;
        end else if (accept) begin
            a_q     <= a_in;
            b_q     <= b_in;
            neg_q   <= neg_in;
            k_q     <= '0;
            carry_q <= '0;
        end else if (state_q == CALC) begin
            prod_q  <= prod_fin;
            carry_q <= colsum >> 1;
            k_q     <= k_q + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.Produto   = prod_q;
endmodule

// File: tb/tb_vedic_multiplier_seq.sv
// Scoreboarded bench: WIDTH=4 directed cases and WIDTH=8 random traffic with output stalls.
module tb_vedic_multiplier_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit stall_en = 1'b0;

    vedic_multiplier_seq_if #(.WIDTH(4)) if4();
    vedic_multiplier_seq_if #(.WIDTH(8)) if8();

    vedic_multiplier_seq #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
    vedic_multiplier_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8));

    logic [7:0]  exp4[$];
    logic [15:0] exp8[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer product, operands reinterpreted as signed when requested.
    function automatic logic [7:0] model4(input int a, input int b, input bit sgn);
        int sa, sb;
        sa = (sgn && a >= 8) ? a - 16 : a;
        sb = (sgn && b >= 8) ? b - 16 : b;
        return 8'(sa * sb);
    endfunction

    function automatic logic [15:0] model8(input int a, input int b);
        return 16'(a * b);
    endfunction

    // Monitors: compare every cycle a product is presented; pop on handshake.
    always @(negedge clk) begin
        if (!rst && if4.out_valid) begin
            if (exp4.size() == 0) check("u4_unexpected_valid", 32'd1, 32'd0);
            else begin
                check("u4_produto", 32'(if4.Produto), 32'(exp4[0]));
                if (if4.out_ready) void'(exp4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if8.out_valid) begin
            if (exp8.size() == 0) check("u8_unexpected_valid", 32'd1, 32'd0);
            else begin
                check("u8_produto", 32'(if8.Produto), 32'(exp8[0]));
                if (if8.out_ready) void'(exp8.pop_front());
            end
        end
    end

    task automatic issue4(input int a, input int b, input bit sgn);
        int n = 0;
        while (!if4.in_ready && n < 60) begin @(posedge clk); #1; n++; end
        if (!if4.in_ready) begin check("u4_ready_timeout", 32'(if4.in_ready), 32'd1); return; end
        if4.A = 4'(a);
        if4.B = 4'(b);
`ifdef VEDIC_SIGNED_EN
        if4.signed_op = sgn;
`endif
        if4.in_valid = 1'b1;
        exp4.push_back(model4(a, b, sgn));
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
    endtask

    task automatic issue8(input int a, input int b);
        int n = 0;
        while (!if8.in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!if8.in_ready) begin check("u8_ready_timeout", 32'(if8.in_ready), 32'd1); return; end
        if8.A = 8'(a);
        if8.B = 8'(b);
        if8.in_valid = 1'b1;
        exp8.push_back(model8(a, b));
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
    endtask

    task automatic drain4();
        int n = 0;
        while ((exp4.size() != 0 || !if4.in_ready) && n < 100) begin @(posedge clk); #1; n++; end
        check("u4_drain", 32'(exp4.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        if4.in_valid = 1'b0; if4.A = '0; if4.B = '0; if4.out_ready = 1'b1;
        if8.in_valid = 1'b0; if8.A = '0; if8.B = '0; if8.out_ready = 1'b1;
`ifdef VEDIC_SIGNED_EN
        if4.signed_op = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready4", 32'(if4.in_ready), 32'd1);
        check("rst_out_valid4", 32'(if4.out_valid), 32'd0);
        check("rst_busy4", 32'(if4.busy), 32'd0);
        check("rst_produto4", 32'(if4.Produto), 32'd0);
        check("rst_in_ready8", 32'(if8.in_ready), 32'd1);
        check("rst_produto8", 32'(if8.Produto), 32'd0);

        // 15*15: out_valid exactly 7 cycles after accept, in_ready low throughout.
        if4.A = 4'd15; if4.B = 4'd15; if4.in_valid = 1'b1;
        exp4.push_back(model4(15, 15, 1'b0));
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        check("lat_in_ready_c0", 32'(if4.in_ready), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c <= 7) begin
                check("lat_out_valid", 32'(if4.out_valid), 32'(c == 7));
                check("lat_in_ready", 32'(if4.in_ready), 32'd0);
            end else begin
                check("lat_idle_ready", 32'(if4.in_ready), 32'd1);
                check("lat_idle_valid", 32'(if4.out_valid), 32'd0);
            end
        end

        issue4(3, 2, 1'b0);
        issue4(0, 3, 1'b0);
        issue4(15, 1, 1'b0);
        drain4();

        // Reset three cycles into a multiply discards it.
        if4.A = 4'd9; if4.B = 4'd7; if4.in_valid = 1'b1;
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(if4.in_ready), 32'd1);
        check("abort_out_valid", 32'(if4.out_valid), 32'd0);
        check("abort_produto", 32'(if4.Produto), 32'd0);
        check("abort_busy", 32'(if4.busy), 32'd0);
        issue4(9, 7, 1'b0);
        drain4();

        // Back-to-back with in_valid held and operands changing during CALC.
        if4.A = 4'd5; if4.B = 4'd6; if4.in_valid = 1'b1;
        exp4.push_back(model4(5, 6, 1'b0));
        exp4.push_back(model4(3, 3, 1'b0));
        @(posedge clk); #1;
        if4.A = 4'd3; if4.B = 4'd3;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (c == 8) check("b2b_idle_ready", 32'(if4.in_ready), 32'd1);
            if (c == 9) begin
                check("b2b_second_accept", 32'(if4.busy), 32'd1);
                if4.in_valid = 1'b0;
                if4.A = 4'd15; if4.B = 4'd15;
            end
        end
        drain4();

`ifdef VEDIC_SIGNED_EN
        issue4(8, 8, 1'b1);
        issue4(13, 5, 1'b1);
        issue4(13, 5, 1'b0);
        issue4(7, 8, 1'b1);
        drain4();
`endif

        // WIDTH=8 random traffic with random output stalls.
        stall_en = 1'b1;
        fork
            begin
                int s = 0;
                while (stall_en) begin
                    if (s > 0) begin if8.out_ready = 1'b0; s--; end
                    else begin
                        if8.out_ready = 1'b1;
                        if ($urandom_range(0, 2) == 0) s = $urandom_range(1, 5);
                    end
                    @(posedge clk); #1;
                end
                if8.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 500; i++) begin
                    int a, b;
                    a = (i == 0) ? 255 : (i == 1) ? 0 : (i == 2) ? 128 : int'($urandom_range(0, 255));
                    b = (i == 0) ? 255 : (i == 1) ? 200 : (i == 2) ? 255 : int'($urandom_range(0, 255));
                    issue8(a, b);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                for (int n = 0; n < 200 && exp8.size() != 0; n++) begin @(posedge clk); #1; end
                stall_en = 1'b0;
            end
        join
        check("u8_drain", 32'(exp8.size()), 32'd0);
        check("u4_final_empty", 32'(exp4.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
